// File: rtl/matrix2x2_pkg.sv
// Shared types and constants for the 2x2 matrix operand loader and its bench.
// Beat indices follow the stream order: A row-major, then B row-major.
package matrix2x2_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam logic [2:0] IDX_A00 = 3'd0;
  localparam logic [2:0] IDX_A01 = 3'd1;
  localparam logic [2:0] IDX_A10 = 3'd2;
  localparam logic [2:0] IDX_A11 = 3'd3;
  localparam logic [2:0] IDX_B00 = 3'd4;
  localparam logic [2:0] IDX_B01 = 3'd5;
  localparam logic [2:0] IDX_B10 = 3'd6;
  localparam logic [2:0] IDX_B11 = 3'd7;

  localparam logic [3:0] JOB_LEN_FULL = 4'd8;
  localparam logic [3:0] JOB_LEN_A    = 4'd4;

  localparam int MULT_LAT = 4;

endpackage

// File: rtl/matrix2x2_operand_loader_if.sv
// Byte stream into the operand loader: valid/ready plus the per-job keep_b hint.
interface matrix2x2_operand_loader_if;
  import matrix2x2_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              keep_b;

  modport master (output in_valid, output in_data, output keep_b, input in_ready);
  modport slave  (input in_valid, input in_data, input keep_b, output in_ready);

endinterface

// File: rtl/matrix2x2_operand_loader.sv
// Assembles A/B operands from a byte stream, pulses the engine start and holds
// operands until done; 1 cycle last-beat to start; in_ready low from FIRE to job_done.
module matrix2x2_operand_loader #(
  parameter int DATA_W     = 8,
  parameter int WAIT_GUARD = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  matrix2x2_operand_loader_if.slave   in_if,
  input  logic                        mult_done,
  output logic                        mult_start,
  output logic [DATA_W-1:0]           a00,
  output logic [DATA_W-1:0]           a01,
  output logic [DATA_W-1:0]           a10,
  output logic [DATA_W-1:0]           a11,
  output logic [DATA_W-1:0]           b00,
  output logic [DATA_W-1:0]           b01,
  output logic [DATA_W-1:0]           b10,
  output logic [DATA_W-1:0]           b11,
  output logic                        busy,
  output logic                        job_done
);
  import matrix2x2_pkg::*;

  localparam int GW = (WAIT_GUARD < 2) ? 1 : $clog2(WAIT_GUARD + 1);

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              job_len_q, job_len_d;
  logic                    b_valid_q, b_valid_d;
  logic                    busy_q, busy_d;
  logic                    job_done_q, job_done_d;
  logic [GW-1:0]           guard_q, guard_d;
  logic [7:0][DATA_W-1:0]  ops_q, ops_d;

  logic                    xfer;
  logic                    last_beat;
  logic [3:0]              cur_len;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    job_len_d  = job_len_q;
    b_valid_d  = b_valid_q;
    busy_d     = busy_q;
    job_done_d = 1'b0;
    guard_d    = guard_q;
    ops_d      = ops_q;

    // in_ready_q is only ever high in LOAD, so it alone qualifies a transfer
    xfer    = in_if.in_valid & in_ready_q;
    cur_len = job_len_q;
    if (xfer && (idx_q == IDX_A00)) begin
      cur_len = (in_if.keep_b && b_valid_q) ? JOB_LEN_A : JOB_LEN_FULL;
    end
    last_beat = xfer && ({1'b0, idx_q} == (cur_len - 4'd1));

    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (xfer) begin
          job_len_d = cur_len;
          busy_d    = 1'b1;
          idx_d     = idx_q + 3'd1;
          case (idx_q)
            IDX_A00: ops_d[IDX_A00] = in_if.in_data;
            IDX_A01: ops_d[IDX_A01] = in_if.in_data;
            IDX_A10: ops_d[IDX_A10] = in_if.in_data;
            IDX_A11: ops_d[IDX_A11] = in_if.in_data;
            IDX_B00: ops_d[IDX_B00] = in_if.in_data;
            IDX_B01: ops_d[IDX_B01] = in_if.in_data;
            IDX_B10: ops_d[IDX_B10] = in_if.in_data;
            IDX_B11: begin
              ops_d[IDX_B11] = in_if.in_data;
              b_valid_d      = 1'b1;
            end
            default: ;
          endcase
          if (last_beat) state_d = FIRE;
        end
      end
      FIRE: begin
        state_d = WAIT;
        guard_d = GW'(WAIT_GUARD);
      end
      WAIT: begin
        // the guard masks a done level left over from the previous job
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (mult_done) begin
          state_d    = LOAD;
          job_done_d = 1'b1;
          busy_d     = 1'b0;
          idx_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      idx_q      <= '0;
      job_len_q  <= JOB_LEN_FULL;
      b_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      guard_q    <= '0;
      ops_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      idx_q      <= idx_d;
      job_len_q  <= job_len_d;
      b_valid_q  <= b_valid_d;
      busy_q     <= busy_d;
      job_done_q <= job_done_d;
      guard_q    <= guard_d;
      ops_q      <= ops_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign mult_start     = (state_q == FIRE);
  assign busy           = busy_q;
  assign job_done       = job_done_q;

  assign a00 = ops_q[IDX_A00];
  assign a01 = ops_q[IDX_A01];
  assign a10 = ops_q[IDX_A10];
  assign a11 = ops_q[IDX_A11];
  assign b00 = ops_q[IDX_B00];
  assign b01 = ops_q[IDX_B01];
  assign b10 = ops_q[IDX_B10];
  assign b11 = ops_q[IDX_B11];

endmodule
